nonce_block_builder: RTL and testbench



---
 rtl/nonce_block_builder.sv | 121 ++++++++++++
 tb/tb_nonce_block_builder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_block_builder.sv
// Builds one padded 16-word SHA-256 second block per core: header tail words,
// per-core nonce, 0x80 pad byte, zero fill and the 640-bit message length.
module nonce_block_builder #(
  parameter int NUM_CORES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] block_addr,
  input  logic [31:0] nonce_base,
  output logic        busy,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [8:0] LAST_CORE = 9'(NUM_CORES - 1);

  state_t      state;
  logic [15:0] msg_q;
  logic [15:0] blk_q;
  logic [31:0] nonce_q;
  logic [1:0]  rc;
  logic [8:0]  n;
  logic [3:0]  w;
  logic [31:0] tail0, tail1, tail2;
  logic [31:0] word;

  assign mem_clk = clk;

  always_comb begin
    word = 32'h0000_0000;
    case (w)
      4'd0:    word = tail0;
      4'd1:    word = tail1;
      4'd2:    word = tail2;
      4'd3:    word = nonce_q + {23'b0, n};
      4'd4:    word = 32'h8000_0000;
      4'd15:   word = 32'd640;
      default: word = 32'h0000_0000;
    endcase
  end

  // Read data trails the address by one cycle, so each tail word is captured
  // two edges after its address is registered; tail2 lands on the first write edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= 16'h0000;
      mem_write_data <= 32'h0000_0000;
      msg_q          <= 16'h0000;
      blk_q          <= 16'h0000;
      nonce_q        <= 32'h0000_0000;
      rc             <= 2'd0;
      n              <= 9'd0;
      w              <= 4'd0;
      tail0          <= 32'h0000_0000;
      tail1          <= 32'h0000_0000;
      tail2          <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          busy   <= 1'b0;
          done   <= 1'b0;
          mem_we <= 1'b0;
          if (start) begin
            msg_q   <= message_addr;
            blk_q   <= block_addr;
            nonce_q <= nonce_base;
            rc      <= 2'd0;
            n       <= 9'd0;
            w       <= 4'd0;
            state   <= READ;
          end
        end
        READ: begin
          busy <= 1'b1;
          rc   <= rc + 2'd1;
          case (rc)
            2'd0: mem_addr <= msg_q + 16'd16;
            2'd1: mem_addr <= msg_q + 16'd17;
            2'd2: begin
              mem_addr <= msg_q + 16'd18;
              tail0    <= mem_read_data;
            end
            2'd3: begin
              tail1 <= mem_read_data;
              state <= WRITE;
            end
          endcase
        end
        WRITE: begin
          mem_we         <= 1'b1;
          mem_addr       <= blk_q + {3'b0, n, 4'b0} + {12'b0, w};
          mem_write_data <= word;
          if (n == 9'd0 && w == 4'd0) tail2 <= mem_read_data;
          w <= w + 4'd1;
          if (w == 4'd15) begin
            n <= n + 9'd1;
            if (n == LAST_CORE) state <= DONE;
          end
        end
        DONE: begin
          mem_we <= 1'b0;
          done   <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_block_builder.sv
// Directed bench: a 2-core and a 16-core instance share one memory-read model;
// expected writes are queued per instance and matched in order.
module tb_nonce_block_builder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start2, start16;
  logic [15:0] message_addr, block_addr;
  logic [31:0] nonce_base;

  logic        busy2, done2, mem_clk2, we2;
  logic [15:0] addr2;
  logic [31:0] wd2, rd2;
  logic        busy16, done16, mem_clk16, we16;
  logic [15:0] addr16;
  logic [31:0] wd16, rd16;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int c0;
  int busy2_cnt = 0, done2_cnt = 0, wr2_cnt = 0, done2_cyc = 0;
  int busy16_cnt = 0, done16_cnt = 0, wr16_cnt = 0, done16_cyc = 0;
  logic [47:0] exp2_q[$];
  logic [47:0] exp16_q[$];
  logic [47:0] e2, e16;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nonce_block_builder #(.NUM_CORES(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .message_addr(message_addr), .block_addr(block_addr), .nonce_base(nonce_base),
    .busy(busy2), .done(done2), .mem_clk(mem_clk2), .mem_we(we2),
    .mem_addr(addr2), .mem_write_data(wd2), .mem_read_data(rd2)
  );

  nonce_block_builder dut16 (
    .clk(clk), .reset(reset), .start(start16),
    .message_addr(message_addr), .block_addr(block_addr), .nonce_base(nonce_base),
    .busy(busy16), .done(done16), .mem_clk(mem_clk16), .mem_we(we16),
    .mem_addr(addr16), .mem_write_data(wd16), .mem_read_data(rd16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Shared memory contents: header tail at 16..18, address-derived elsewhere.
  function automatic logic [31:0] rom(input logic [15:0] a);
    case (a)
      16'd16:  rom = 32'h1111_1111;
      16'd17:  rom = 32'h2222_2222;
      16'd18:  rom = 32'h3333_3333;
      default: rom = {~a, a};
    endcase
  endfunction

  always @(posedge clk) begin
    rd2  <= rom(addr2);
    rd16 <= rom(addr16);
  end

  task automatic push_run(input bit big, input logic [15:0] ma, input logic [15:0] ba,
                          input logic [31:0] nb, input int cores);
    logic [31:0] t0, t1, t2, d;
    logic [15:0] a;
    t0 = rom(ma + 16'd16);
    t1 = rom(ma + 16'd17);
    t2 = rom(ma + 16'd18);
    for (int n = 0; n < cores; n++) begin
      for (int w = 0; w < 16; w++) begin
        a = ba + 16'(n * 16 + w);
        case (w)
          0:       d = t0;
          1:       d = t1;
          2:       d = t2;
          3:       d = nb + 32'(n);
          4:       d = 32'h8000_0000;
          15:      d = 32'd640;
          default: d = 32'h0000_0000;
        endcase
        if (big) exp16_q.push_back({a, d});
        else     exp2_q.push_back({a, d});
      end
    end
  endtask

  always @(negedge clk) begin
    if (busy2) busy2_cnt++;
    if (done2) begin done2_cnt++; done2_cyc = cyc; end
    if (we2) begin
      wr2_cnt++;
      chk("wr2_has_exp", 64'(exp2_q.size() != 0), 64'd1);
      if (exp2_q.size() != 0) begin
        e2 = exp2_q.pop_front();
        chk("wr2_addr_data", 64'({addr2, wd2}), 64'(e2));
      end
    end
    if (busy16) busy16_cnt++;
    if (done16) begin done16_cnt++; done16_cyc = cyc; end
    if (we16) begin
      wr16_cnt++;
      chk("wr16_has_exp", 64'(exp16_q.size() != 0), 64'd1);
      if (exp16_q.size() != 0) begin
        e16 = exp16_q.pop_front();
        chk("wr16_addr_data", 64'({addr16, wd16}), 64'(e16));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic launch2(input logic [15:0] ma, input logic [15:0] ba,
                         input logic [31:0] nb, input bit check_reads);
    step();
    message_addr = ma;
    block_addr   = ba;
    nonce_base   = nb;
    start2       = 1'b1;
    step();
    start2 = 1'b0;
    c0     = cyc;
    if (check_reads) begin
      step();
      chk("rd_addr_16", 64'(addr2), 64'(16'(ma + 16'd16)));
      chk("rd_we_low", 64'(we2), 64'd0);
      chk("busy_after_start", 64'(busy2), 64'd1);
      step();
      chk("rd_addr_17", 64'(addr2), 64'(16'(ma + 16'd17)));
      step();
      chk("rd_addr_18", 64'(addr2), 64'(16'(ma + 16'd18)));
    end
  endtask

  task automatic wait_done2(input int d0, input int exp_cyc);
    for (int i = 0; i < 300 && done2_cnt == d0; i++) step();
    chk("done2_pulse", 64'(done2_cnt - d0), 64'd1);
    chk("done2_cycle", 64'(done2_cyc), 64'(exp_cyc));
  endtask

  int d0, b0, w0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start2 = 1'b0;
    start16 = 1'b0;
    message_addr = 16'h0;
    block_addr = 16'h0;
    nonce_base = 32'h0;
    step(); step(); step();
    chk("rst_busy", 64'(busy2), 64'd0);
    chk("rst_done", 64'(done2), 64'd0);
    chk("rst_we", 64'(we2), 64'd0);
    chk("rst_addr", 64'(addr2), 64'd0);
    chk("rst_wdata", 64'(wd2), 64'd0);
    chk("mem_clk_low", 64'(mem_clk2), 64'(clk));
    reset = 1'b0;
    step();

    // Basic run
    push_run(1'b0, 16'h0000, 16'h0100, 32'd5, 2);
    d0 = done2_cnt; b0 = busy2_cnt; w0 = wr2_cnt;
    launch2(16'h0000, 16'h0100, 32'd5, 1'b1);
    @(posedge clk); #1;
    chk("mem_clk_high", 64'(mem_clk2), 64'(clk));
    wait_done2(d0, c0 + 37);
    chk("basic_busy_in_done", 64'(busy2), 64'd1);
    step();
    chk("basic_idle_busy", 64'(busy2), 64'd0);
    chk("basic_idle_we", 64'(we2), 64'd0);
    chk("basic_hold_wdata", 64'(wd2), 64'd640);
    chk("basic_busy_cycles", 64'(busy2_cnt - b0), 64'd37);
    chk("basic_writes", 64'(wr2_cnt - w0), 64'd32);
    chk("basic_q_drained", 64'(exp2_q.size()), 64'd0);

    // Nonce wrap, non-zero message address
    push_run(1'b0, 16'h0200, 16'h0300, 32'hFFFF_FFFF, 2);
    d0 = done2_cnt;
    launch2(16'h0200, 16'h0300, 32'hFFFF_FFFF, 1'b1);
    wait_done2(d0, c0 + 37);
    step();
    chk("nwrap_q_drained", 64'(exp2_q.size()), 64'd0);

    // Block address wrap
    push_run(1'b0, 16'h0000, 16'hFFF8, 32'h0000_1234, 2);
    d0 = done2_cnt;
    launch2(16'h0000, 16'hFFF8, 32'h0000_1234, 1'b0);
    wait_done2(d0, c0 + 37);
    step();
    chk("awrap_q_drained", 64'(exp2_q.size()), 64'd0);

    // Start while busy is ignored; held start retriggers right after DONE
    push_run(1'b0, 16'h0000, 16'h0400, 32'd100, 2);
    d0 = done2_cnt;
    launch2(16'h0000, 16'h0400, 32'd100, 1'b0);
    while (cyc != c0 + 9) step();
    message_addr = 16'h0040;
    block_addr   = 16'h0800;
    nonce_base   = 32'hDEAD_0000;
    start2       = 1'b1;
    step();
    start2 = 1'b0;
    while (cyc != c0 + 20) step();
    message_addr = 16'h0010;
    block_addr   = 16'h0500;
    nonce_base   = 32'd200;
    start2       = 1'b1;
    push_run(1'b0, 16'h0010, 16'h0500, 32'd200, 2);
    wait_done2(d0, c0 + 37);
    step();
    start2 = 1'b0;
    c0 = c0 + 38;
    chk("retrig_busy", 64'(busy2), 64'd0);
    step();
    chk("retrig_busy_next", 64'(busy2), 64'd1);
    wait_done2(d0 + 1, c0 + 37);
    step();
    chk("retrig_q_drained", 64'(exp2_q.size()), 64'd0);

    // Reset mid-WRITE
    push_run(1'b0, 16'h0000, 16'h0600, 32'h77, 2);
    w0 = wr2_cnt;
    launch2(16'h0000, 16'h0600, 32'h77, 1'b0);
    while (cyc != c0 + 11) step();
    @(posedge clk); #2;
    chk("pre_rst_we", 64'(we2), 64'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_we", 64'(we2), 64'd0);
    chk("async_rst_busy", 64'(busy2), 64'd0);
    chk("async_rst_done", 64'(done2), 64'd0);
    chk("rst_writes_before", 64'(wr2_cnt - w0), 64'd7);
    exp2_q.delete();
    step(); step();
    reset = 1'b0;
    d0 = done2_cnt; w0 = wr2_cnt;
    repeat (40) step();
    chk("post_rst_no_writes", 64'(wr2_cnt - w0), 64'd0);
    chk("post_rst_no_done", 64'(done2_cnt - d0), 64'd0);
    chk("post_rst_idle", 64'(busy2), 64'd0);
    push_run(1'b0, 16'h0010, 16'h0700, 32'h10, 2);
    launch2(16'h0010, 16'h0700, 32'h10, 1'b1);
    wait_done2(d0, c0 + 37);
    step();
    chk("post_rst_writes", 64'(wr2_cnt - w0), 64'd32);
    chk("post_rst_q_drained", 64'(exp2_q.size()), 64'd0);

    // Capacity: default 16 cores
    push_run(1'b1, 16'h0000, 16'h1000, 32'hABCD_0000, 16);
    d0 = done16_cnt; b0 = busy16_cnt; w0 = wr16_cnt;
    step();
    message_addr = 16'h0000;
    block_addr   = 16'h1000;
    nonce_base   = 32'hABCD_0000;
    start16      = 1'b1;
    step();
    start16 = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 400 && done16_cnt == d0; i++) step();
    chk("cap_done_pulse", 64'(done16_cnt - d0), 64'd1);
    chk("cap_done_cycle", 64'(done16_cyc), 64'(c0 + 261));
    repeat (3) step();
    chk("cap_busy_cycles", 64'(busy16_cnt - b0), 64'd261);
    chk("cap_writes", 64'(wr16_cnt - w0), 64'd256);
    chk("cap_single_done", 64'(done16_cnt - d0), 64'd1);
    chk("cap_q_drained", 64'(exp16_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
